step_phase_decoder: RTL

STEP_PHASE_DECODER -- requirements
Module: step_phase_decoder

---
 rtl/step_phase_decoder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/step_phase_decoder.sv
// Four-phase stepper coil decoder: signed position, direction, step strobe and step period in ms.
// Optional macro FAULT_DETECT_EN enables the sticky FAULT state for illegal or skipped phases.
module step_phase_decoder #(
    parameter logic [15:0] T1MS = 16'd49999
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [3:0]         stepmotor,
    input  logic               clr,
    output logic signed [15:0] position,
    output logic               dir,
    output logic               step_pulse,
    output logic [7:0]         period_ms,
    output logic               running,
    output logic               fault
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
`ifdef FAULT_DETECT_EN
    localparam logic [1:0] ST_FAULT = 2'd2;
`endif

    logic [3:0]         sync1_q, sync2_q;
    logic [1:0]         state_q, state_d;
    logic [3:0]         ref_q, ref_d;
    logic signed [15:0] pos_q, pos_d;
    logic               dir_q, dir_d;
    logic               pulse_q, pulse_d;
    logic [7:0]         period_q, period_d;
    logic [15:0]        presc_q, presc_d;
    logic [7:0]         ms_q, ms_d;
    logic               run_q, run_d;
    logic               step_evt;

    logic       phase_legal, is_fwd, is_bwd, tick;
    logic [3:0] fwd_ph, bwd_ph;
    logic [7:0] ms_inc;

    assign phase_legal = (sync2_q == 4'b0001) || (sync2_q == 4'b0010) ||
                         (sync2_q == 4'b0100) || (sync2_q == 4'b1000);
    assign fwd_ph = {ref_q[2:0], ref_q[3]};
    assign bwd_ph = {ref_q[0], ref_q[3:1]};
    assign is_fwd = phase_legal && (sync2_q == fwd_ph);
    assign is_bwd = phase_legal && (sync2_q == bwd_ph);

`ifdef FAULT_DETECT_EN
    logic fault_q, fault_d;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        pulse_d  = 1'b0;
        step_evt = 1'b0;
`ifdef FAULT_DETECT_EN
        fault_d  = fault_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (phase_legal) begin
                    ref_d   = sync2_q;
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (is_fwd) begin
                    pos_d    = pos_q + 16'sd1;
                    dir_d    = 1'b1;
                    pulse_d  = 1'b1;
                    step_evt = 1'b1;
                    ref_d    = sync2_q;
                end else if (is_bwd) begin
                    pos_d    = pos_q - 16'sd1;
                    dir_d    = 1'b0;
                    pulse_d  = 1'b1;
                    step_evt = 1'b1;
                    ref_d    = sync2_q;
                end else if ((sync2_q == ref_q) || (sync2_q == 4'b0000)) begin
                    state_d = ST_TRACK;
                end else begin
`ifdef FAULT_DETECT_EN
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
`else
                    // A legal phase two positions away resynchronises silently.
                    if (phase_legal) ref_d = sync2_q;
`endif
                end
            end
`ifdef FAULT_DETECT_EN
            ST_FAULT: state_d = ST_FAULT;
`endif
            default: state_d = ST_IDLE;
        endcase

        if (!clr) begin
            state_d = state_d;
        end else begin
            state_d  = ST_IDLE;
            ref_d    = 4'b0000;
            pos_d    = 16'sd0;
            dir_d    = 1'b0;
            pulse_d  = 1'b0;
            step_evt = 1'b0;
`ifdef FAULT_DETECT_EN
            fault_d  = 1'b0;
`endif
        end
    end

    // Period capture includes a tick landing on the step edge, so an exact N ms spacing reads N.
    assign tick   = (presc_q == T1MS);
    assign ms_inc = (tick && (ms_q != 8'hFF)) ? ms_q + 8'd1 : ms_q;

    always_comb begin
        presc_d  = tick ? 16'd0 : presc_q + 16'd1;
        ms_d     = ms_inc;
        period_d = period_q;
        run_d    = (ms_inc == 8'hFF) ? 1'b0 : run_q;
        if (clr) begin
            presc_d  = 16'd0;
            ms_d     = 8'd0;
            period_d = 8'd0;
            run_d    = 1'b0;
        end else if (step_evt) begin
            period_d = ms_inc;
            presc_d  = 16'd0;
            ms_d     = 8'd0;
            run_d    = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q  <= 4'b0000;
            sync2_q  <= 4'b0000;
            state_q  <= ST_IDLE;
            ref_q    <= 4'b0000;
            pos_q    <= 16'sd0;
            dir_q    <= 1'b0;
            pulse_q  <= 1'b0;
            period_q <= 8'd0;
            presc_q  <= 16'd0;
            ms_q     <= 8'd0;
            run_q    <= 1'b0;
        end else begin
            sync1_q  <= stepmotor;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            ref_q    <= ref_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            pulse_q  <= pulse_d;
            period_q <= period_d;
            presc_q  <= presc_d;
            ms_q     <= ms_d;
            run_q    <= run_d;
        end
    end

`ifdef FAULT_DETECT_EN
    always_ff @(posedge clk) begin
        if (!rstn) fault_q <= 1'b0;
        else       fault_q <= fault_d;
    end
`endif

    assign position   = pos_q;
    assign dir        = dir_q;
    assign step_pulse = pulse_q;
    assign period_ms  = period_q;
    assign running    = run_q;

endmodule
